multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OP_W, default 6, meaning opcode width; it must hold opcodes 0..33.
REQ-002 SHALL have parameter MUL_LAT, default 3, meaning EXEC cycles for MUL, range 1..15.
REQ-003 SHALL have port clk  in  1  rising-edge clock; one clock, all state on clk.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port op  in  OP_W  opcode, sampled only on accept.
REQ-006 SHALL have port instr_valid  in  1  opcode offered.
REQ-007 SHALL have port instr_ready  out  1  block idle, can accept.
REQ-008 SHALL have port zero  in  1  ALU zero flag, used by BEQ.
REQ-009 SHALL have port mem_ack  in  1  memory transfer done.
REQ-010 SHALL have port alu_ctrl  out  4  0 add, 1 sub, 2 mul, 3 and, 4 or.
REQ-011 SHALL have port pc_sel  out  3  0 PC+4, 1 branch target, 2 jump target, 3 EPC, 4 trap vector; valid only with pc_we.
REQ-012 SHALL have port pc_we  out  1  one-cycle PC update strobe.
REQ-013 SHALL have ports mem_read, mem_write, mem_byte, mem_reg, alu_src, reg_write, tlb_write, illegal_op  out  1 each  datapath controls.

Function
REQ-014 SHALL accept when instr_valid and instr_ready are both 1 on a clk edge, registering op into op_q; op is ignored at all other times.
REQ-015 SHALL use states IDLE, DECODE, EXEC, MEM, WB, TRAP; instr_ready = 1 only in IDLE.
REQ-016 SHALL go IDLE->DECODE on accept; DECODE lasts exactly one cycle.
REQ-017 SHALL, from DECODE, go to EXEC for ADD 0, SUB 1, MUL 2, AND 3, OR 4, MOV 14, BEQ 30, JUMP 31, TLBWRITE 32, IRET 33; to MEM for LBD 10, LDW 11, STB 12, STW 13; to TRAP for any other value.
REQ-018 SHALL drive alu_ctrl = opcode for ops 0..4 in EXEC; go EXEC->WB after 1 cycle, or after MUL_LAT cycles for MUL (4-bit down-counter loaded in DECODE).
REQ-019 SHALL, for MOV, drive alu_src=1 and alu_ctrl=0 in EXEC, then go to WB.
REQ-020 SHALL, for BEQ, drive alu_ctrl=1 and pc_we=1 in EXEC with pc_sel=1 if zero=1 else 0, then go IDLE.
REQ-021 SHALL, in EXEC, drive pc_we=1 with pc_sel=2 for JUMP; pc_we=1, pc_sel=0, tlb_write=1 for TLBWRITE; pc_we=1, pc_sel=3 for IRET; each then goes IDLE.
REQ-022 SHALL, in MEM, hold mem_read (LBD/LDW) or mem_write (STB/STW) high every cycle until mem_ack=1, with mem_byte=1 for LBD/STB; no timeout.
REQ-023 SHALL, on mem_ack in MEM, go to WB for loads, or pulse pc_we (pc_sel=0) in that cycle and go IDLE for stores.
REQ-024 SHALL, in WB, pulse reg_write=1 and pc_we=1 (pc_sel=0) for one cycle, with mem_reg=1 for loads and 0 otherwise, then go IDLE.
REQ-025 SHALL, in TRAP, pulse illegal_op=1 and pc_we=1 with pc_sel=4 for one cycle, then go IDLE.
REQ-026 SHALL drive every control output 0 in any state or cycle where it is not stated above.
REQ-027 SHALL ignore mem_ack outside MEM and zero outside BEQ EXEC.

Reset
REQ-028 SHALL, when rst_n=0, immediately force state=IDLE, op_q=0 and counter=0, with all outputs 0 except instr_ready=1.
REQ-029 SHALL, on reset mid-instruction (e.g. MUL count, pending MEM), abandon it with no pc_we or reg_write afterward.

Configuration
REQ-030 SHALL, with CTRL_MUL_EN defined, execute MUL per REQ-018.
REQ-031 SHALL, without CTRL_MUL_EN, decode MUL 2 as illegal (DECODE->TRAP), omit the counter, and never drive alu_ctrl=2.

Verification
REQ-032 SHALL cover: ADD (op=0) accepted at cycle 0 -> DECODE cycle 1, alu_ctrl=0 cycle 2, reg_write=pc_we=1 cycle 3, instr_ready=1 cycle 4.
REQ-033 SHALL cover: MUL with CTRL_MUL_EN, MUL_LAT=3 -> alu_ctrl=2 for exactly 3 cycles, then WB; without the macro -> illegal_op=1, pc_sel=4, no reg_write.
REQ-034 SHALL cover: LDW with mem_ack delayed 4 cycles -> mem_read=1 for 5 cycles, mem_byte=0, then WB with mem_reg=1; STB acked at once -> mem_write=1, mem_byte=1, pc_we in that cycle, no reg_write.
REQ-035 SHALL cover: BEQ with zero=1 -> pc_sel=1; with zero=0 -> pc_sel=0; IRET -> pc_sel=3; TLBWRITE -> tlb_write=1 for one cycle.
REQ-036 SHALL cover: op=7 -> TRAP with illegal_op=1 for one cycle; instr_valid held high while busy -> no second accept before IDLE.
REQ-037 SHALL cover: rst_n dropped in the 2nd MEM wait cycle -> outputs 0 at once, instr_ready=1, no later pc_we.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose: control FSM for a small multicycle datapath. One opcode is accepted
// while idle, decoded for one cycle, then sequenced through EXEC, MEM, WB or
// TRAP. All datapath controls are decoded combinationally from the current
// state and the latched opcode.
//
// Optional feature: define CTRL_MUL_EN to execute MUL (opcode 2) for MUL_LAT
// EXEC cycles using a 4-bit down-counter. Without it, MUL decodes as illegal,
// the counter does not exist, and alu_ctrl never takes the value 2.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   op           in   opcode, sampled only on accept
//   instr_valid  in   opcode offered
//   instr_ready  out  high only in IDLE
//   zero         in   ALU zero flag (BEQ only)
//   mem_ack      in   memory transfer done (MEM only)
//   alu_ctrl     out  0 add, 1 sub, 2 mul, 3 and, 4 or
//   pc_sel       out  0 PC+4, 1 branch, 2 jump, 3 EPC, 4 trap vector
//   pc_we        out  one-cycle PC update strobe
//   mem_read, mem_write, mem_byte, mem_reg, alu_src, reg_write, tlb_write,
//   illegal_op   out  datapath controls
//   dbg_state_o  out  current FSM state (debug visibility)
//
// Handshake: an instruction is accepted on a rising edge where instr_valid and
// instr_ready are both 1; op is latched then and ignored at every other time.
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter int OP_W    = 6,
   parameter int MUL_LAT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic            zero,
   input  logic            mem_ack,
   output logic [3:0]      alu_ctrl,
   output logic [2:0]      pc_sel,
   output logic            pc_we,
   output logic            mem_read,
   output logic            mem_write,
   output logic            mem_byte,
   output logic            mem_reg,
   output logic            alu_src,
   output logic            reg_write,
   output logic            tlb_write,
   output logic            illegal_op,
   output logic [2:0]      dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MUL   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
   localparam logic [OP_W-1:0] OP_LBD   = OP_W'(10);
   localparam logic [OP_W-1:0] OP_LDW   = OP_W'(11);
   localparam logic [OP_W-1:0] OP_STB   = OP_W'(12);
   localparam logic [OP_W-1:0] OP_STW   = OP_W'(13);
   localparam logic [OP_W-1:0] OP_MOV   = OP_W'(14);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(30);
   localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(31);
   localparam logic [OP_W-1:0] OP_TLBW  = OP_W'(32);
   localparam logic [OP_W-1:0] OP_IRET  = OP_W'(33);

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;

   logic is_load;
   logic is_byte;

   assign is_load = (op_q == OP_LBD) || (op_q == OP_LDW);
   assign is_byte = (op_q == OP_LBD) || (op_q == OP_STB);

   assign dbg_state_o = state_q;

`ifdef CTRL_MUL_EN
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
`ifdef CTRL_MUL_EN
      cnt_d       = cnt_q;
`endif
      instr_ready = 1'b0;
      alu_ctrl    = 4'd0;
      pc_sel      = 3'd0;
      pc_we       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_byte    = 1'b0;
      mem_reg     = 1'b0;
      alu_src     = 1'b0;
      reg_write   = 1'b0;
      tlb_write   = 1'b0;
      illegal_op  = 1'b0;

      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               op_d    = op;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            case (op_q)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV,
               OP_BEQ, OP_JUMP, OP_TLBW, OP_IRET: state_d = S_EXEC;
`ifdef CTRL_MUL_EN
               OP_MUL: begin
                  state_d = S_EXEC;
                  cnt_d   = 4'(MUL_LAT);
               end
`endif
               OP_LBD, OP_LDW, OP_STB, OP_STW: state_d = S_MEM;
               default: state_d = S_TRAP;
            endcase
         end

         S_EXEC: begin
            case (op_q)
               OP_ADD: begin alu_ctrl = 4'd0; state_d = S_WB; end
               OP_SUB: begin alu_ctrl = 4'd1; state_d = S_WB; end
               OP_AND: begin alu_ctrl = 4'd3; state_d = S_WB; end
               OP_OR:  begin alu_ctrl = 4'd4; state_d = S_WB; end
`ifdef CTRL_MUL_EN
               OP_MUL: begin
                  // Counter was loaded with MUL_LAT in DECODE; leave on the
                  // cycle it reads 1 so EXEC lasts exactly MUL_LAT cycles.
                  alu_ctrl = 4'd2;
                  cnt_d    = cnt_q - 4'd1;
                  if (cnt_q <= 4'd1) state_d = S_WB;
               end
`endif
               OP_MOV: begin
                  alu_src  = 1'b1;
                  alu_ctrl = 4'd0;
                  state_d  = S_WB;
               end
               OP_BEQ: begin
                  alu_ctrl = 4'd1;
                  pc_we    = 1'b1;
                  pc_sel   = zero ? 3'd1 : 3'd0;
                  state_d  = S_IDLE;
               end
               OP_JUMP: begin
                  pc_we   = 1'b1;
                  pc_sel  = 3'd2;
                  state_d = S_IDLE;
               end
               OP_TLBW: begin
                  pc_we     = 1'b1;
                  pc_sel    = 3'd0;
                  tlb_write = 1'b1;
                  state_d   = S_IDLE;
               end
               OP_IRET: begin
                  pc_we   = 1'b1;
                  pc_sel  = 3'd3;
                  state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end

         S_MEM: begin
            // Request stays asserted until acknowledged; there is no timeout.
            mem_read  = is_load;
            mem_write = !is_load;
            mem_byte  = is_byte;
            if (mem_ack) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  pc_we   = 1'b1;
                  pc_sel  = 3'd0;
                  state_d = S_IDLE;
               end
            end
         end

         S_WB: begin
            reg_write = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 3'd0;
            mem_reg   = is_load;
            state_d   = S_IDLE;
         end

         S_TRAP: begin
            illegal_op = 1'b1;
            pc_we      = 1'b1;
            pc_sel     = 3'd4;
            state_d    = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Outputs are packed into one vector
// {instr_ready, alu_ctrl, pc_sel, pc_we, mem_read, mem_write, mem_byte,
// mem_reg, alu_src, reg_write, tlb_write, illegal_op} and compared against
// hand-written expectations at the falling edge of each cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int OP_W = 6;

   logic            clk;
   logic            rst_n;
   logic [OP_W-1:0] op;
   logic            instr_valid;
   logic            instr_ready;
   logic            zero;
   logic            mem_ack;
   logic [3:0]      alu_ctrl;
   logic [2:0]      pc_sel;
   logic            pc_we;
   logic            mem_read;
   logic            mem_write;
   logic            mem_byte;
   logic            mem_reg;
   logic            alu_src;
   logic            reg_write;
   logic            tlb_write;
   logic            illegal_op;
   logic [2:0]      dbg_state;

   logic [16:0] outs;
   logic [16:0] e;
   int          total;
   int          passed;

   // flag order: we, rd, wr, byte, mreg, asrc, rw, tlb, ill
   localparam logic [8:0] F_WE  = 9'h100;
   localparam logic [8:0] F_RD  = 9'h080;
   localparam logic [8:0] F_WR  = 9'h040;
   localparam logic [8:0] F_BY  = 9'h020;
   localparam logic [8:0] F_MR  = 9'h010;
   localparam logic [8:0] F_AS  = 9'h008;
   localparam logic [8:0] F_RW  = 9'h004;
   localparam logic [8:0] F_TLB = 9'h002;
   localparam logic [8:0] F_ILL = 9'h001;

   assign outs = {instr_ready, alu_ctrl, pc_sel, pc_we, mem_read, mem_write,
                  mem_byte, mem_reg, alu_src, reg_write, tlb_write, illegal_op};

   function automatic logic [16:0] ev(input logic rdy, input logic [3:0] alu,
                                      input logic [2:0] sel, input logic [8:0] flg);
      return {rdy, alu, sel, flg};
   endfunction

   multicycle_control #(.OP_W(OP_W), .MUL_LAT(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .zero        (zero),
      .mem_ack     (mem_ack),
      .alu_ctrl    (alu_ctrl),
      .pc_sel      (pc_sel),
      .pc_we       (pc_we),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_byte    (mem_byte),
      .mem_reg     (mem_reg),
      .alu_src     (alu_src),
      .reg_write   (reg_write),
      .tlb_write   (tlb_write),
      .illegal_op  (illegal_op),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one opcode in IDLE; returns just after the accepting edge (DECODE).
   task automatic accept(input logic [OP_W-1:0] o);
      op          = o;
      instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0;
      op          = $urandom_range(63, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_valid = 1'b0; op = '0; zero = 1'b0; mem_ack = 1'b0;
      #12;
      e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL reset_outs got=%h exp=%h", outs, e); else passed++;
      total++;
      if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else passed++;
      @(negedge clk); rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_add();
      accept(6'd0);
      zero = 1'b1; mem_ack = 1'b1;   // both must be ignored here
      @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL add_decode got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL add_exec got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_RW); total++;
      if (outs !== e) $display("FAIL add_wb got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL add_idle got=%h exp=%h", outs, e); else passed++;
      zero = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic test_alu_ops();
      logic [5:0] ops [3] = '{6'd1, 6'd3, 6'd4};
      for (int i = 0; i < 3; i++) begin
         accept(ops[i]);
         cyc(); @(negedge clk); e = ev(1'b0, ops[i][3:0], 3'd0, 9'h0); total++;
         if (outs !== e) $display("FAIL alu_exec op=%0d got=%h exp=%h", ops[i], outs, e); else passed++;
         cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_RW); total++;
         if (outs !== e) $display("FAIL alu_wb op=%0d got=%h exp=%h", ops[i], outs, e); else passed++;
         cyc();
      end
      // MOV
      accept(6'd14);
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_AS); total++;
      if (outs !== e) $display("FAIL mov_exec got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_RW); total++;
      if (outs !== e) $display("FAIL mov_wb got=%h exp=%h", outs, e); else passed++;
      cyc();
   endtask

   task automatic test_mul();
      accept(6'd2);
`ifdef CTRL_MUL_EN
      for (int i = 0; i < 3; i++) begin
         cyc(); @(negedge clk); e = ev(1'b0, 4'd2, 3'd0, 9'h0); total++;
         if (outs !== e) $display("FAIL mul_exec%0d got=%h exp=%h", i, outs, e); else passed++;
      end
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_RW); total++;
      if (outs !== e) $display("FAIL mul_wb got=%h exp=%h", outs, e); else passed++;
`else
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd4, F_WE | F_ILL); total++;
      if (outs !== e) $display("FAIL mul_trap got=%h exp=%h", outs, e); else passed++;
`endif
      cyc(); @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL mul_idle got=%h exp=%h", outs, e); else passed++;
   endtask

   task automatic test_load_delayed();
      accept(6'd11);
      for (int i = 0; i < 5; i++) begin
         cyc();
         mem_ack = (i == 4);
         @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_RD); total++;
         if (outs !== e) $display("FAIL ldw_mem%0d got=%h exp=%h", i, outs, e); else passed++;
      end
      cyc(); mem_ack = 1'b0;
      @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_RW | F_MR); total++;
      if (outs !== e) $display("FAIL ldw_wb got=%h exp=%h", outs, e); else passed++;
      cyc();
   endtask

   task automatic test_store_byte();
      accept(6'd12);
      cyc(); mem_ack = 1'b1;
      @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WR | F_BY | F_WE); total++;
      if (outs !== e) $display("FAIL stb_mem got=%h exp=%h", outs, e); else passed++;
      cyc(); mem_ack = 1'b0;
      @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL stb_idle got=%h exp=%h", outs, e); else passed++;
   endtask

   task automatic test_branches();
      accept(6'd30);
      cyc(); zero = 1'b1;
      @(negedge clk); e = ev(1'b0, 4'd1, 3'd1, F_WE); total++;
      if (outs !== e) $display("FAIL beq_taken got=%h exp=%h", outs, e); else passed++;
      cyc(); zero = 1'b0;
      accept(6'd30);
      cyc();
      @(negedge clk); e = ev(1'b0, 4'd1, 3'd0, F_WE); total++;
      if (outs !== e) $display("FAIL beq_not_taken got=%h exp=%h", outs, e); else passed++;
      cyc();
      accept(6'd31);
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd2, F_WE); total++;
      if (outs !== e) $display("FAIL jump got=%h exp=%h", outs, e); else passed++;
      cyc();
      accept(6'd33);
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd3, F_WE); total++;
      if (outs !== e) $display("FAIL iret got=%h exp=%h", outs, e); else passed++;
      cyc();
      accept(6'd32);
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_TLB); total++;
      if (outs !== e) $display("FAIL tlbwrite got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL tlbwrite_after got=%h exp=%h", outs, e); else passed++;
   endtask

   task automatic test_illegal();
      accept(6'd7);
      @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL ill_decode got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd4, F_WE | F_ILL); total++;
      if (outs !== e) $display("FAIL ill_trap got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL ill_idle got=%h exp=%h", outs, e); else passed++;
   endtask

   task automatic test_back_to_back();
      // ADD offered, then AND offered continuously while busy.
      op = 6'd0; instr_valid = 1'b1;
      cyc();
      op = 6'd3;
      @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL b2b_decode got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL b2b_exec_add got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_WE | F_RW); total++;
      if (outs !== e) $display("FAIL b2b_wb got=%h exp=%h", outs, e); else passed++;
      cyc(); @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL b2b_idle got=%h exp=%h", outs, e); else passed++;
      cyc(); instr_valid = 1'b0;   // second accept happened on that edge
      cyc(); @(negedge clk); e = ev(1'b0, 4'd3, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL b2b_exec_and got=%h exp=%h", outs, e); else passed++;
      cyc(); cyc();
   endtask

   task automatic test_reset_mid_mem();
      accept(6'd11);
      cyc();         // MEM wait 1
      cyc();         // MEM wait 2
      @(negedge clk); e = ev(1'b0, 4'd0, 3'd0, F_RD); total++;
      if (outs !== e) $display("FAIL rst_pre got=%h exp=%h", outs, e); else passed++;
      #1 rst_n = 1'b0;
      #1; e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
      if (outs !== e) $display("FAIL rst_immediate got=%h exp=%h", outs, e); else passed++;
      @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(); @(negedge clk); e = ev(1'b1, 4'd0, 3'd0, 9'h0); total++;
         if (outs !== e) $display("FAIL rst_after%0d got=%h exp=%h", i, outs, e); else passed++;
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      total = 0; passed = 0;
      test_reset();
      test_add();
      test_alu_ops();
      test_mul();
      test_load_delayed();
      test_store_byte();
      test_branches();
      test_illegal();
      test_back_to_back();
      test_reset_mid_mem();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
